// File: rtl/button_event_tracker_pkg.sv
// Shared io_circuits constants: channel FSM state encoding and the event-bit
// ordering used by the MMIO status register.
package button_event_tracker_pkg;

    // Channel state encoding; values are visible to software through debug reads.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StHeld    = 2'd2
    } btn_state_e;

    // Bit positions of each event inside a per-channel event vector.
    localparam int unsigned EvtPress   = 0;
    localparam int unsigned EvtRelease = 1;
    localparam int unsigned EvtHold    = 2;
    localparam int unsigned EvtRepeat  = 3;
    localparam int unsigned EvtNumBits = 4;

    // Larger of two unsigned values, usable in parameter expressions.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button channel: edge detect, press/hold/repeat state machine, tick counter
// and registered single-cycle event outputs.
module button_event_fsm
    import button_event_tracker_pkg::*;
#(
    parameter int unsigned HOLD_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter int unsigned CNT_WIDTH    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  din,
    input  logic                  tick,
    output logic [EvtNumBits-1:0] evt,
    output logic                  held
);

    localparam logic [CNT_WIDTH-1:0] HoldCnt   = CNT_WIDTH'(HOLD_TICKS);
    localparam logic [CNT_WIDTH-1:0] RepeatCnt = CNT_WIDTH'(REPEAT_TICKS);
    localparam bit                   RepeatEn  = (REPEAT_TICKS != 0);

    logic                  in_q;
    btn_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [EvtNumBits-1:0] evt_q, evt_d;
    logic                  rise, fall, step;

    assign rise    = din & ~in_q;
    assign fall    = ~din & in_q;
    // Only ticks seen while the button is still down advance the counter.
    assign step    = tick & din;
    assign cnt_inc = cnt_q + 1'b1;

    // Next state, counter and event decode; a fall overrides any tick this cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = '0;
        if (fall) begin
            evt_d[EvtRelease] = 1'b1;
            state_d           = StIdle;
            cnt_d             = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A tick coinciding with the press edge is deliberately not counted.
                    if (rise) begin
                        evt_d[EvtPress] = 1'b1;
                        state_d         = StPressed;
                        cnt_d           = '0;
                    end
                end
                StPressed: begin
                    if (step) begin
                        if (cnt_inc == HoldCnt) begin
                            evt_d[EvtHold] = 1'b1;
                            state_d        = StHeld;
                            cnt_d          = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                StHeld: begin
                    // With auto-repeat disabled the counter simply parks at zero.
                    if (step && RepeatEn) begin
                        if (cnt_inc == RepeatCnt) begin
                            evt_d[EvtRepeat] = 1'b1;
                            cnt_d            = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, input history and event registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q    <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
            evt_q   <= '0;
        end else begin
            in_q    <= din;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign evt  = evt_q;
    assign held = (state_q == StHeld);

endmodule

// File: rtl/button_event_tracker.sv
// Converts debounced button levels into press/release/hold/repeat events using
// a shared free-running tick prescaler and one FSM per channel.
module button_event_tracker
    import button_event_tracker_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned TICK_CNT_MAX   = 125000,
    parameter int unsigned HOLD_TICKS     = 500,
    parameter int unsigned REPEAT_TICKS   = 100,
    parameter int unsigned TICK_CNT_WIDTH = $clog2(TICK_CNT_MAX) + 1,
    parameter int unsigned EVT_CNT_WIDTH  = $clog2(max_u(HOLD_TICKS, REPEAT_TICKS)) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    output logic [WIDTH-1:0] hold_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic [WIDTH-1:0] held_level
);

    localparam logic [TICK_CNT_WIDTH-1:0] TickLast = TICK_CNT_WIDTH'(TICK_CNT_MAX - 1);

    logic [TICK_CNT_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic                      tick;

    assign tick       = (tick_cnt_q == TickLast);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Free-running prescaler; never restarted by button activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [EvtNumBits-1:0] ch_evt;
        logic                  ch_held;

        button_event_fsm #(
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .CNT_WIDTH    (EVT_CNT_WIDTH)
        ) u_fsm (
            .clk  (clk),
            .rst  (rst),
            .din  (debounced_signal[i]),
            .tick (tick),
            .evt  (ch_evt),
            .held (ch_held)
        );

        assign press_pulse[i]   = ch_evt[EvtPress];
        assign release_pulse[i] = ch_evt[EvtRelease];
        assign hold_pulse[i]    = ch_evt[EvtHold];
        assign repeat_pulse[i]  = ch_evt[EvtRepeat];
        assign held_level[i]    = ch_held;
    end

endmodule

// File: tb/tb_button_event_tracker.sv
// Self-checking bench: per-cycle comparison against a tick-counting event model
// plus directed latency and cadence checks.
module tb_button_event_tracker;

    localparam int W   = 2;
    localparam int TCK = 4;
    localparam int HT  = 3;
    localparam int RT  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] debounced_signal;
    logic [W-1:0] press_pulse, release_pulse, hold_pulse, repeat_pulse, held_level;

    button_event_tracker #(
        .WIDTH        (W),
        .TICK_CNT_MAX (TCK),
        .HOLD_TICKS   (HT),
        .REPEAT_TICKS (RT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .debounced_signal (debounced_signal),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .hold_pulse       (hold_pulse),
        .repeat_pulse     (repeat_pulse),
        .held_level       (held_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model: counts ticks observed while a button stays down since its press.
    int           cyc = 0;
    int           m_cyc = 0;
    bit           model_valid = 1'b0;
    bit           m_prev [W];
    bit           m_down [W];
    int           m_ticks[W];
    logic [W-1:0] exp_press, exp_release, exp_hold, exp_repeat, exp_held;

    initial begin
        bit m_tick;
        bit din;
        forever begin
            @(posedge clk);
            cyc++;
            exp_press   = '0;
            exp_release = '0;
            exp_hold    = '0;
            exp_repeat  = '0;
            exp_held    = '0;
            if (rst) begin
                m_cyc = 0;
                for (int i = 0; i < W; i++) begin
                    m_prev[i]  = 1'b0;
                    m_down[i]  = 1'b0;
                    m_ticks[i] = 0;
                end
            end else begin
                m_tick = ((m_cyc % TCK) == TCK - 1);
                m_cyc++;
                for (int i = 0; i < W; i++) begin
                    din = debounced_signal[i];
                    if (din && !m_prev[i]) begin
                        exp_press[i] = 1'b1;
                        m_down[i]    = 1'b1;
                        m_ticks[i]   = 0;
                    end else if (!din && m_prev[i]) begin
                        exp_release[i] = 1'b1;
                        m_down[i]      = 1'b0;
                        m_ticks[i]     = 0;
                    end else if (din && m_down[i] && m_tick) begin
                        m_ticks[i]++;
                        if (m_ticks[i] == HT) exp_hold[i] = 1'b1;
                        else if (m_ticks[i] > HT && RT != 0 && ((m_ticks[i] - HT) % RT) == 0)
                            exp_repeat[i] = 1'b1;
                    end
                    exp_held[i] = m_down[i] && (m_ticks[i] >= HT);
                    m_prev[i]   = din;
                end
            end
            model_valid = 1'b1;
        end
    end

    // Event history derived from DUT outputs for the literal latency checks.
    int press_cyc[W];
    int last_hr  [W];
    int hold_cnt [W];
    int rep_cnt  [W];

    initial begin
        for (int i = 0; i < W; i++) begin
            press_cyc[i] = -1000;
            last_hr[i]   = -1;
            hold_cnt[i]  = 0;
            rep_cnt[i]   = 0;
        end
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check("press_pulse", 32'(press_pulse), 32'(exp_press));
                check("release_pulse", 32'(release_pulse), 32'(exp_release));
                check("hold_pulse", 32'(hold_pulse), 32'(exp_hold));
                check("repeat_pulse", 32'(repeat_pulse), 32'(exp_repeat));
                check("held_level", 32'(held_level), 32'(exp_held));
                for (int i = 0; i < W; i++) begin
                    if (press_pulse[i] === 1'b1) begin
                        press_cyc[i] = cyc;
                        last_hr[i]   = -1;
                    end
                    if (hold_pulse[i] === 1'b1) begin
                        hold_cnt[i]++;
                        check_range("hold_latency", cyc - press_cyc[i], 9, 12);
                        last_hr[i] = cyc;
                    end
                    if (repeat_pulse[i] === 1'b1) begin
                        rep_cnt[i]++;
                        if (last_hr[i] >= 0) check("repeat_period", 32'(cyc - last_hr[i]), 32'd8);
                        last_hr[i] = cyc;
                    end
                end
            end
        end
    end

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int r0;
        rst              = 1'b1;
        debounced_signal = '0;

        // Reset then idle: everything stays quiet.
        repeat (5) settle();
        rst = 1'b0;
        repeat (20) settle();
        check("idle_outputs", 32'({press_pulse, release_pulse, hold_pulse, repeat_pulse,
                                   held_level}), 32'd0);

        // Short press: press and release, no hold.
        debounced_signal[0] = 1'b1;
        settle();
        check("short_press_lat", 32'(press_pulse[0]), 32'd1);
        settle();
        check("short_press_once", 32'(press_pulse[0]), 32'd0);
        repeat (3) settle();
        debounced_signal[0] = 1'b0;
        settle();
        check("short_release_lat", 32'(release_pulse[0]), 32'd1);
        settle();
        check("short_release_once", 32'(release_pulse[0]), 32'd0);
        check("short_no_hold", 32'(hold_cnt[0]), 32'd0);

        // Long press: hold then repeats every 8 cycles.
        repeat (3) settle();
        debounced_signal[0] = 1'b1;
        repeat (50) settle();
        check("long_hold_count", 32'(hold_cnt[0]), 32'd1);
        check("long_repeats_seen", 32'(rep_cnt[0] >= 4), 32'd1);
        check("long_held_level", 32'(held_level[0]), 32'd1);
        debounced_signal[0] = 1'b0;
        settle();
        check("long_release", 32'(release_pulse[0]), 32'd1);
        check("long_held_drop", 32'(held_level[0]), 32'd0);

        // Release coinciding with the tick that would complete the hold.
        repeat (3) settle();
        for (int k = 0; k < 8 && (m_cyc % TCK) != TCK - 1; k++) settle();
        settle();
        debounced_signal[0] = 1'b1;
        repeat (11) settle();
        debounced_signal[0] = 1'b0;
        settle();
        check("race_release", 32'(release_pulse[0]), 32'd1);
        check("race_no_hold_pulse", 32'(hold_pulse[0]), 32'd0);
        check("race_hold_count", 32'(hold_cnt[0]), 32'd1);

        // Channel 1 activity while channel 0 repeats.
        repeat (3) settle();
        debounced_signal[0] = 1'b1;
        repeat (20) settle();
        r0 = rep_cnt[0];
        debounced_signal[1] = 1'b1;
        settle();
        check("ch1_press", 32'(press_pulse[1]), 32'd1);
        repeat (2) settle();
        debounced_signal[1] = 1'b0;
        settle();
        check("ch1_release", 32'(release_pulse[1]), 32'd1);
        repeat (20) settle();
        check("ch0_repeats_continue", 32'(rep_cnt[0] - r0 >= 2), 32'd1);
        check("ch1_no_hold", 32'(hold_cnt[1]), 32'd0);

        // Reset pulse while channel 0 is held and still pressed.
        check("pre_rst_held", 32'(held_level[0]), 32'd1);
        rst = 1'b1;
        settle();
        check("rst_held_clear", 32'(held_level[0]), 32'd0);
        check("rst_no_release", 32'(release_pulse[0]), 32'd0);
        rst = 1'b0;
        settle();
        check("post_rst_press", 32'(press_pulse[0]), 32'd1);
        repeat (5) settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
